dm_lsu: RTL

- Load/store initiator that drives the data memory (DM) port on behalf of the core pipeline.
- Translates byte, halfword and word loads/stores into DM word accesses:
  - checks the address window;
  - sign- or zero-extends loads;
  - does read-modify-write for sub-word stores, because DM has only a word write enable.
- Sits between the execute stage and DM. Stalls the pipeline via busy_o.

---
 rtl/dm_lsu_if.sv | 27 ++
 rtl/dm_lsu.sv | 80 ++++++++
 2 files changed

// File: rtl/dm_lsu_if.sv
// dm_lsu_if: core-side load/store request bundle plus the data-memory port.
// slave  : seen by dm_lsu (takes requests and DM read data, drives status and the DM address, write data and write enable)
// master : seen by the core/DM side (drives requests and DM read data)
interface dm_lsu_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        fault_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_wd_o;
    logic        dm_we_o;
    logic [31:0] dm_rd_i;
    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, dm_rd_i,
        output busy_o, done_o, rdata_o, fault_o, dm_addr_o, dm_wd_o, dm_we_o
    );
    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, dm_rd_i,
        input  busy_o, done_o, rdata_o, fault_o, dm_addr_o, dm_wd_o, dm_we_o
    );
endinterface

// File: rtl/dm_lsu.sv
// dm_lsu: byte/half/word load-store initiator for a word-only data memory.
// Ports: clk_i (rising-edge clock), rstn_i (async active-low reset), bus (dm_lsu_if.slave:
//   core request/response and DM port). Sub-word stores use read-modify-write.
// Optional: define DM_LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses;
//   otherwise the low address bits are forced to the natural alignment.
module dm_lsu #(
    parameter logic [31:0] DM_BASE  = 32'h6600_0000,
    parameter int          DM_WORDS = 1024
) (
    input  logic     clk_i,
    input  logic     rstn_i,
    dm_lsu_if.slave  bus
);
    localparam logic [31:0] WIN = 32'(DM_WORDS * 4);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP, FAULT} state_t;
    state_t      r_state, w_next;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_merge, r_rdata;
    logic [31:0] w_off, w_ext, w_mask, w_merged;
    logic [15:0] w_lane;
    logic [4:0]  w_sh;
    logic        w_mis, w_bad;
    // Addresses below DM_BASE wrap to large offsets and fail the window test.
    assign w_off = bus.addr_i - DM_BASE;
`ifdef DM_LSU_MISALIGN_TRAP_EN
    assign w_mis = (bus.size_i == 2'b01 && bus.addr_i[0]) || (bus.size_i == 2'b10 && bus.addr_i[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif
    assign w_bad = (w_off >= WIN) || (bus.size_i == 2'b11) || w_mis;
    // Lane position: byte uses addr[1:0], half uses {addr[1],0}; word ignores it.
    assign w_sh     = (r_size == 2'b00) ? {r_addr[1:0], 3'b000} : {r_addr[1], 4'b0000};
    assign w_lane   = 16'(bus.dm_rd_i >> w_sh);
    assign w_ext    = (r_size == 2'b00) ? {{24{~r_uns & w_lane[7]}}, w_lane[7:0]} :
                      (r_size == 2'b01) ? {{16{~r_uns & w_lane[15]}}, w_lane} : bus.dm_rd_i;
    assign w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    assign w_merged = (bus.dm_rd_i & ~w_mask) | ((r_wdata << w_sh) & w_mask);
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_merge <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req_i) begin
                r_uns   <= bus.unsigned_i;
                r_size  <= bus.size_i;
                r_addr  <= bus.addr_i;
                r_wdata <= bus.wdata_i;
            end
            if (r_state == LOAD) r_rdata <= w_ext;
            if (r_state == RMW_RD) r_merge <= w_merged;
        end
    end
    // Store direction is carried by the state path, so no separate we register is kept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        if (bus.req_i) w_next = w_bad ? FAULT : !bus.we_i ? LOAD : (bus.size_i == 2'b10) ? WRITE : RMW_RD;
            LOAD:        w_next = RESP;
            RMW_RD:      w_next = WRITE;
            WRITE:       w_next = RESP;
            default:     w_next = IDLE;
        endcase
    end
    always_comb begin
        bus.busy_o    = r_state != IDLE;
        bus.done_o    = r_state == RESP || r_state == FAULT;
        bus.fault_o   = r_state == FAULT;
        bus.dm_we_o   = r_state == WRITE;
        bus.dm_addr_o = (r_state == LOAD || r_state == RMW_RD || r_state == WRITE) ? {r_addr[31:2], 2'b00} : '0;
        bus.dm_wd_o   = (r_state != WRITE) ? '0 : (r_size == 2'b10) ? r_wdata : r_merge;
    end
    assign bus.rdata_o = r_rdata;
endmodule
